// File: rtl/rotfpga_scan_ctrl.sv
// Scan-chain configuration controller: loads a chain image from host words, or reads it back by recirculation.
// Latency: IN_W+1 cycles per loaded word; readback holds each word until rd_ready. Backpressure: host_ready/rd_ready handshakes.
// Optional CRC-8 over scan_in bits when ROTFPGA_SCAN_CRC_EN is defined; otherwise crc is tied to zero.
`timescale 1ns/1ps
module rotfpga_scan_ctrl #(
    parameter int CHAIN_LEN = 64,
    parameter int IN_W      = 8,
    parameter int CNT_W     = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_load,
    input  logic            start_read,
    input  logic            abort,
    input  logic            host_valid,
    output logic            host_ready,
    input  logic [IN_W-1:0] host_data,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [IN_W-1:0] rd_data,
    output logic            scan_en,
    output logic            scan_in,
    input  logic            scan_out,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [7:0]      crc
);

    localparam int BIT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LD_WAIT,
        LD_SHIFT,
        RD_SHIFT,
        RD_HOLD,
        FIN
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [BIT_W-1:0]  bcnt;
    logic [IN_W-1:0]   shreg;
    logic [IN_W-1:0]   cap;
    logic [IN_W:0]     cap_shift;
    logic              err_q;
    logic              start;
    logic              last_bit;
    logic              cancel;

    assign start     = (state == IDLE) && (start_load || start_read);
    assign cancel    = abort && (state != IDLE);
    assign cnt_inc   = cnt + 1'b1;
    assign last_bit  = (bcnt == BIT_W'(IN_W - 1));
    assign cap_shift = {scan_out, cap};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        host_ready = 1'b0;
        rd_valid   = 1'b0;
        scan_en    = 1'b0;
        scan_in    = 1'b0;
        done       = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start_load) begin
                    state_n = LD_WAIT;
                end else if (start_read) begin
                    state_n = RD_SHIFT;
                end
            end
            LD_WAIT: begin
                host_ready = 1'b1;
                if (host_valid) begin
                    state_n = LD_SHIFT;
                end
            end
            LD_SHIFT: begin
                scan_en = 1'b1;
                scan_in = shreg[0];
                if (last_bit) begin
                    state_n = (cnt_inc == CNT_W'(CHAIN_LEN)) ? FIN : LD_WAIT;
                end
            end
            RD_SHIFT: begin
                // Feed the tail back to the head so the image survives a full pass.
                scan_en = 1'b1;
                scan_in = scan_out;
                if (last_bit) begin
                    state_n = RD_HOLD;
                end
            end
            RD_HOLD: begin
                rd_valid = 1'b1;
                if (rd_ready) begin
                    state_n = (cnt == CNT_W'(CHAIN_LEN)) ? FIN : RD_SHIFT;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // Cancel wins over everything: no shift, no handshake, no done on this cycle.
        if (cancel) begin
            state_n    = IDLE;
            host_ready = 1'b0;
            rd_valid   = 1'b0;
            scan_en    = 1'b0;
            scan_in    = 1'b0;
            done       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            bcnt <= '0;
        end else if (start) begin
            cnt  <= '0;
            bcnt <= '0;
        end else if (scan_en) begin
            cnt  <= cnt_inc;
            bcnt <= last_bit ? '0 : bcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (host_ready && host_valid) begin
            shreg <= host_data;
        end else if (scan_en && (state == LD_SHIFT)) begin
            shreg <= shreg >> 1;
        end
    end

    // First captured bit walks down from the MSB and ends at the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap <= '0;
        end else if (scan_en && (state == RD_SHIFT)) begin
            cap <= cap_shift[IN_W:1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (start) begin
            err_q <= 1'b0;
        end else if (cancel) begin
            err_q <= 1'b1;
        end
    end

    assign rd_data = cap;
    assign err     = err_q;

`ifdef ROTFPGA_SCAN_CRC_EN
    logic [7:0] crc_q;
    logic       crc_fb;

    assign crc_fb = crc_q[7] ^ scan_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 8'h00;
        end else if (start) begin
            crc_q <= 8'h00;
        end else if (scan_en) begin
            crc_q <= {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
        end
    end

    assign crc = crc_q;
`else
    assign crc = 8'h00;
`endif

endmodule

// File: tb/tb_rotfpga_scan_ctrl.sv
// Directed bench for rotfpga_scan_ctrl with a 16-bit grid chain model and bit/word scoreboards.
`timescale 1ns/1ps
module tb_rotfpga_scan_ctrl;

    localparam int CL = 16;
    localparam int W  = 8;
    localparam int CW = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_load = 1'b0;
    logic         start_read = 1'b0;
    logic         abort = 1'b0;
    logic         host_valid = 1'b0;
    logic         host_ready;
    logic [W-1:0] host_data = '0;
    logic         rd_valid;
    logic         rd_ready = 1'b0;
    logic [W-1:0] rd_data;
    logic         scan_en;
    logic         scan_in;
    logic         scan_out;
    logic         busy;
    logic         done;
    logic         err;
    logic [7:0]   crc;

    always #5 clk = ~clk;

    rotfpga_scan_ctrl #(.CHAIN_LEN(CL), .IN_W(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start_load(start_load), .start_read(start_read),
        .abort(abort), .host_valid(host_valid), .host_ready(host_ready), .host_data(host_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out),
        .busy(busy), .done(done), .err(err), .crc(crc)
    );

    // Grid chain: first bit in emerges at the tail first.
    logic [CL-1:0] chain = '0;
    assign scan_out = chain[CL-1];
    always @(posedge clk) if (scan_en) chain <= {chain[CL-2:0], scan_in};

    int errors = 0;
    int checks = 0;
    int sen_cnt = 0;
    int done_cnt = 0;
    bit rd_mode = 1'b0;
    logic         exp_bits[$];
    logic [W-1:0] exp_words[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] crc_ref(input logic [15:0] seq);
        logic [7:0] c;
        logic fb;
        c = 8'h00;
        for (int i = 0; i < 16; i++) begin
            fb = c[7] ^ seq[i];
            c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    function automatic logic [7:0] exp_crc(input logic [15:0] seq);
`ifdef ROTFPGA_SCAN_CRC_EN
        return crc_ref(seq);
`else
        return (seq == 16'h0) ? 8'h00 : 8'h00;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (scan_en) begin
                sen_cnt++;
                if (rd_mode) check("recirc", 32'(scan_in), 32'(scan_out));
                else if (exp_bits.size() == 0) check("extra_shift", 32'(scan_en), 0);
                else check("scan_in", 32'(scan_in), 32'(exp_bits.pop_front()));
            end
            if (rd_valid && rd_ready) begin
                if (exp_words.size() == 0) check("extra_word", 32'(rd_valid), 0);
                else check("rd_data", 32'(rd_data), 32'(exp_words.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 500) begin
            tick();
            n++;
        end
        check(tag, 32'(busy), 0);
    endtask

    task automatic feed(input logic [W-1:0] w);
        int n;
        n = 0;
        while (!host_ready && n < 200) begin
            tick();
            n++;
        end
        check("host_ready_wait", 32'(host_ready), 1);
        for (int i = 0; i < W; i++) exp_bits.push_back(w[i]);
        host_valid = 1'b1;
        host_data  = w;
        tick();
        host_valid = 1'b0;
    endtask

    task automatic do_load(input logic [W-1:0] w0, input logic [W-1:0] w1);
        rd_mode = 1'b0;
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        feed(w0);
        feed(w1);
        wait_idle("load_idle");
    endtask

    task automatic start_rd();
        rd_mode = 1'b1;
        start_read = 1'b1;
        tick();
        start_read = 1'b0;
    endtask

    task automatic push_chain_words();
        for (int k = 0; k < CL / W; k++) begin
            logic [W-1:0] w;
            for (int j = 0; j < W; j++) w[j] = chain[CL-1-(k*W+j)];
            exp_words.push_back(w);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0, n;
        logic [CL-1:0] snap, img;
        logic [15:0] seq;
        seq = 16'h3CA5;
        for (int i = 0; i < CL; i++) img[CL-1-i] = seq[i];

        // Reset values
        #3;
        check("rst_busy", 32'(busy), 0);
        check("rst_host_ready", 32'(host_ready), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_scan_en", 32'(scan_en), 0);
        check("rst_scan_in", 32'(scan_in), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_crc", 32'(crc), 0);
        check("rst_cnt", 32'(dut.cnt), 0);
        #10;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Load 0xA5, 0x3C
        s0 = sen_cnt; d0 = done_cnt;
        do_load(8'hA5, 8'h3C);
        check("load_shifts", sen_cnt - s0, 16);
        check("load_done", done_cnt - d0, 1);
        check("load_bits_left", exp_bits.size(), 0);
        check("load_image", 32'(chain), 32'(img));
        check("load_crc", 32'(crc), 32'(exp_crc(seq)));

        // Readback, consumer always ready
        rd_ready = 1'b1;
        exp_words.push_back(8'hA5);
        exp_words.push_back(8'h3C);
        snap = chain; s0 = sen_cnt; d0 = done_cnt;
        start_rd();
        wait_idle("read_idle");
        check("read_words_left", exp_words.size(), 0);
        check("read_restore", 32'(chain), 32'(snap));
        check("read_shifts", sen_cnt - s0, 16);
        check("read_done", done_cnt - d0, 1);
        check("read_crc", 32'(crc), 32'(exp_crc(seq)));

        // Readback with consumer stalled on the first word
        rd_ready = 1'b0;
        exp_words.push_back(8'hA5);
        exp_words.push_back(8'h3C);
        start_rd();
        n = 0;
        while (!rd_valid && n < 100) begin
            tick();
            n++;
        end
        check("stall_rd_valid", 32'(rd_valid), 1);
        for (int i = 0; i < 5; i++) begin
            check("stall_scan_en", 32'(scan_en), 0);
            check("stall_rd_data", 32'(rd_data), 32'hA5);
            check("stall_cnt", 32'(dut.cnt), 8);
            tick();
        end
        rd_ready = 1'b1;
        wait_idle("stall_idle");
        check("stall_words_left", exp_words.size(), 0);
        check("stall_restore", 32'(chain), 32'(snap));

        // Simultaneous starts: load wins
        d0 = done_cnt;
        rd_mode = 1'b0;
        start_load = 1'b1;
        start_read = 1'b1;
        tick();
        start_load = 1'b0;
        start_read = 1'b0;
        check("both_host_ready", 32'(host_ready), 1);
        check("both_scan_en", 32'(scan_en), 0);
        check("both_rd_valid", 32'(rd_valid), 0);
        feed(8'hA5);
        feed(8'h3C);
        wait_idle("both_idle");
        check("both_done", done_cnt - d0, 1);
        check("both_image", 32'(chain), 32'(img));
        check("both_no_capture", 32'(rd_data), 32'h3C);

        // Abort after 5 load shifts
        d0 = done_cnt;
        rd_mode = 1'b0;
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        feed(8'hA5);
        s0 = sen_cnt;
        for (int i = 0; i < 5; i++) tick();
        abort = 1'b1;
        #1;
        check("abort_host_ready", 32'(host_ready), 0);
        check("abort_busy_before", 32'(busy), 1);
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_err", 32'(err), 1);
        check("abort_done_now", 32'(done), 0);
        exp_bits.delete();
        tick();
        check("abort_err_sticky", 32'(err), 1);
        check("abort_shifts", sen_cnt - s0, 5);
        check("abort_no_done", done_cnt - d0, 0);
        push_chain_words();
        start_rd();
        check("start_clears_err", 32'(err), 0);
        wait_idle("abort_read_idle");
        check("abort_read_words_left", exp_words.size(), 0);

        // Async reset mid-read
        push_chain_words();
        start_rd();
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_scan_en", 32'(scan_en), 0);
        check("arst_scan_in", 32'(scan_in), 0);
        check("arst_rd_valid", 32'(rd_valid), 0);
        check("arst_host_ready", 32'(host_ready), 0);
        check("arst_done", 32'(done), 0);
        check("arst_err", 32'(err), 0);
        check("arst_rd_data", 32'(rd_data), 0);
        check("arst_crc", 32'(crc), 0);
        exp_words.delete();
        #3;
        rst_n = 1'b1;
        tick();

        // Full load/read after reset
        d0 = done_cnt;
        do_load(8'hA5, 8'h3C);
        check("post_image", 32'(chain), 32'(img));
        check("post_load_crc", 32'(crc), 32'(exp_crc(seq)));
        exp_words.push_back(8'hA5);
        exp_words.push_back(8'h3C);
        start_rd();
        wait_idle("post_read_idle");
        check("post_words_left", exp_words.size(), 0);
        check("post_restore", 32'(chain), 32'(img));
        check("post_done", done_cnt - d0, 2);
        check("post_read_crc", 32'(crc), 32'(exp_crc(seq)));

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
